// File: rtl/aiv_pixel_sampler_if.sv
// ---------------------------------------------------------------------------
// aiv_pixel_sampler_if
//   Groups the oversampled video input and the recovered pixel output of the
//   AIV pixel sampler into one bundle.
//
//   Video source side (driven by the sync regenerator / capture front end):
//     rgb_in      [2:0]  {r,g,b} already synchronised to the sampling clock
//     hsync              regenerated hsync, active high
//     vsync              regenerated vsync, active high
//     isFieldOdd         field parity from the sync regenerator
//   Pixel side (driven by the sampler, consumed by the framebuffer writer):
//     pixel_data  [2:0]  majority-voted pixel {r,g,b}
//     pixel_valid        one-cycle strobe per active pixel
//     pixel_x     [9:0]  active dot index
//     pixel_y     [9:0]  interlaced frame line index
//     frame_start        high with the valid of the first pixel of a frame
//     sync_lost          no hsync seen for too long
//
//   master : the video source (drives the inputs, observes the pixels)
//   slave  : the sampler itself
// ---------------------------------------------------------------------------
interface aiv_pixel_sampler_if;
  logic [2:0] rgb_in;
  logic       hsync;
  logic       vsync;
  logic       isFieldOdd;
  logic [2:0] pixel_data;
  logic       pixel_valid;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       frame_start;
  logic       sync_lost;

  modport master (
    output rgb_in, hsync, vsync, isFieldOdd,
    input  pixel_data, pixel_valid, pixel_x, pixel_y, frame_start, sync_lost
  );

  modport slave (
    input  rgb_in, hsync, vsync, isFieldOdd,
    output pixel_data, pixel_valid, pixel_x, pixel_y, frame_start, sync_lost
  );
endinterface

// File: rtl/aiv_pixel_sampler.sv
// ---------------------------------------------------------------------------
// aiv_pixel_sampler
//   Recovers discrete BBC Master AIV pixels from an RGB111 stream that is
//   oversampled at sysClk. A fractional (8.8 fixed point) phase accumulator
//   is restarted on every hsync rising edge and strobes once per AIV pixel;
//   each strobe takes a 3-tap majority vote of the incoming colour bits.
//   Active pixels are emitted with x/y coordinates and a frame-start marker.
//   Loss of line sync is flagged when hsync stays away for too long.
//
//   Ports:
//     clk      sampling clock (sysClk, 81 MHz)
//     nReset   asynchronous active-low reset
//     bus      aiv_pixel_sampler_if.slave (video in, pixels out)
// ---------------------------------------------------------------------------
module aiv_pixel_sampler #(
  parameter int PERIOD_FX        = 1296,
  parameter int SAMPLE_OFFSET_FX = 648,
  parameter int H_START_DOTS     = 96,
  parameter int ACTIVE_DOTS      = 640,
  parameter int V_START          = 23,
  parameter int ACTIVE_LINES     = 288,
  parameter int LINE_TIMEOUT     = 6000
) (
  input  logic               clk,
  input  logic               nReset,
  aiv_pixel_sampler_if.slave bus
);

  localparam int TW = $clog2(LINE_TIMEOUT + 1);

  localparam logic [15:0]   PERIOD_W   = 16'(PERIOD_FX);
  localparam logic [15:0]   ACC_START  = 16'(PERIOD_FX - SAMPLE_OFFSET_FX);
  localparam logic [15:0]   ACC_STEP   = 16'd256;
  localparam logic [9:0]    H_LAST     = 10'(H_START_DOTS - 1);
  localparam logic [9:0]    DOT_LAST   = 10'(ACTIVE_DOTS - 1);
  localparam logic [10:0]   V_START_W  = 11'(V_START);
  localparam logic [10:0]   V_END_W    = 11'(V_START + ACTIVE_LINES);
  localparam logic [TW-1:0] TMO_MAX    = TW'(LINE_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST   = TW'(LINE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    ACTIVE
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   acc_q, acc_d;
  logic [9:0]    dot_q, dot_d;
  logic [9:0]    fieldLine_q, fieldLine_d;
  logic [9:0]    lineIdx_q, lineIdx_d;
  logic          fieldOdd_q, fieldOdd_d;
  logic          hsPrev_q, vsPrev_q;
  logic [2:0]    rgbD1_q, rgbD2_q;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          syncLost_q, syncLost_d;
  logic          valid_q, valid_d;
  logic [2:0]    data_q, data_d;
  logic [9:0]    x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic          fs_q, fs_d;

  logic          hsEdge, vsEdge;
  logic          tick, timeoutHit;
  logic [15:0]   accSum;
  logic [2:0]    vote;
  logic [9:0]    yVal;
  logic [9:0]    lineBase;
  logic          lineInRange;

  // Edge detection, majority vote and line-to-frame-line mapping.
  // The vote uses the live input as the newest tap so a tick looks at
  // samples t-2, t-1 and t.
  always_comb begin
    hsEdge = bus.hsync & ~hsPrev_q;
    vsEdge = bus.vsync & ~vsPrev_q;
    accSum = acc_q + ACC_STEP;
    vote   = (bus.rgb_in & rgbD1_q) | (bus.rgb_in & rgbD2_q) | (rgbD1_q & rgbD2_q);
    yVal   = 10'((({1'b0, lineIdx_q} - V_START_W) << 1) + {10'd0, ~fieldOdd_q});
  end

  // Next-state logic. Priority, lowest to highest: normal phase/tick
  // progress, sync timeout, vsync (restarts the field), hsync (restarts the
  // line). A coincident vsync makes the hsync start field line 0.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    dot_d       = dot_q;
    fieldLine_d = fieldLine_q;
    lineIdx_d   = lineIdx_q;
    fieldOdd_d  = fieldOdd_q;
    tmo_d       = tmo_q;
    syncLost_d  = syncLost_q;
    valid_d     = 1'b0;
    data_d      = data_q;
    x_d         = x_q;
    y_d         = y_q;
    fs_d        = fs_q;
    tick        = 1'b0;
    timeoutHit  = 1'b0;
    lineBase    = fieldLine_q;
    lineInRange = 1'b0;

    if (tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + 1'b1;
    end
    timeoutHit = (tmo_q == TMO_LAST);

    if ((state_q != IDLE) && !hsEdge && !vsEdge) begin
      if (accSum >= PERIOD_W) begin
        tick  = 1'b1;
        acc_d = accSum - PERIOD_W;
      end else begin
        acc_d = accSum;
      end
    end

    if (tick && !timeoutHit) begin
      case (state_q)
        BLANK: begin
          if (dot_q == H_LAST) begin
            dot_d   = 10'd0;
            state_d = ACTIVE;
          end else begin
            dot_d = dot_q + 10'd1;
          end
        end
        ACTIVE: begin
          valid_d = 1'b1;
          data_d  = vote;
          x_d     = dot_q;
          y_d     = yVal;
          fs_d    = (dot_q == 10'd0) && (yVal == 10'd0);
          dot_d   = dot_q + 10'd1;
          if (dot_q == DOT_LAST) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (timeoutHit) begin
      syncLost_d = 1'b1;
      state_d    = IDLE;
    end

    if (vsEdge) begin
      fieldLine_d = 10'd0;
      lineBase    = 10'd0;
      fieldOdd_d  = bus.isFieldOdd;
      state_d     = IDLE;
    end

    if (hsEdge) begin
      lineIdx_d   = lineBase;
      fieldLine_d = (lineBase == 10'd1023) ? lineBase : lineBase + 10'd1;
      acc_d       = ACC_START;
      dot_d       = 10'd0;
      tmo_d       = '0;
      syncLost_d  = 1'b0;
      lineInRange = ({1'b0, lineBase} >= V_START_W) && ({1'b0, lineBase} < V_END_W);
      if (!lineInRange) begin
        state_d = IDLE;
      end else if (H_START_DOTS == 0) begin
        state_d = ACTIVE;
      end else begin
        state_d = BLANK;
      end
    end
  end

  // State and output registers. Clearing the previous-sync registers on
  // reset means a sync level already high at release is seen as an edge.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      acc_q       <= 16'd0;
      dot_q       <= 10'd0;
      fieldLine_q <= 10'd0;
      lineIdx_q   <= 10'd0;
      fieldOdd_q  <= 1'b0;
      hsPrev_q    <= 1'b0;
      vsPrev_q    <= 1'b0;
      rgbD1_q     <= 3'd0;
      rgbD2_q     <= 3'd0;
      tmo_q       <= '0;
      syncLost_q  <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= 3'd0;
      x_q         <= 10'd0;
      y_q         <= 10'd0;
      fs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      dot_q       <= dot_d;
      fieldLine_q <= fieldLine_d;
      lineIdx_q   <= lineIdx_d;
      fieldOdd_q  <= fieldOdd_d;
      hsPrev_q    <= bus.hsync;
      vsPrev_q    <= bus.vsync;
      rgbD1_q     <= bus.rgb_in;
      rgbD2_q     <= rgbD1_q;
      tmo_q       <= tmo_d;
      syncLost_q  <= syncLost_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      x_q         <= x_d;
      y_q         <= y_d;
      fs_q        <= fs_d;
    end
  end

  assign bus.pixel_data  = data_q;
  assign bus.pixel_valid = valid_q;
  assign bus.pixel_x     = x_q;
  assign bus.pixel_y     = y_q;
  assign bus.frame_start = fs_q;
  assign bus.sync_lost   = syncLost_q;

endmodule
